vga_scanout: RTL and testbench
==============================

# vga_scanout

Read-side controller for the 320x240x12-bit VGA frame buffer RAM. It generates 640x480@60 Hz VGA timing from the system clock and issues `row_read`/`col_read` addresses to the buffer's read port. Each stored pixel is shown as a 2x2 block. It drives 4-bit-per-channel RGB with active-low syncs to the board connector. The image pipeline writes the same RAM through its write port; this block never writes.

## Interface
- `CLK_DIV`, 4: system clocks per VGA pixel; legal values are 2 and above (100 MHz / 4 = 25 MHz).
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in pixels.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `row_read`  out  8  buffer read row (0..239).
- `col_read`  out  9  buffer read column (0..319).
- `pixel_out`  in  12  buffer read data; valid 1 `clk` after the address; bits [11:8]=R, [7:4]=G, [3:0]=B.
- `vga_red`, `vga_green`, `vga_blue`  out  4 each  colour outputs; 0 during blanking.
- `vga_hsync`, `vga_vsync`  out  1 each  active-low sync pulses.
- `frame_start`  out  1  one-`clk` pulse when the counters wrap to (h=0, v=0).

## Operation
- Divider `div` counts 0..CLK_DIV-1. `tick` = (`div` == CLK_DIV-1).
- Pixel counters advance only on `tick`:
  - `h` counts 0..H_TOTAL-1, where H_TOTAL = 800.
  - `v` counts 0..V_TOTAL-1, where V_TOTAL = 525, and increments when `h` wraps.
  - `v` wraps after 524; `frame_start` is asserted on the `clk` where `h` and `v` both become 0.
- `vis` = (h < 640) && (v < 480).
- Address generation:
  - `col_read` = vis ? h[9:1] : 0.
  - `row_read` = vis ? v[8:1] : 0.
  - Both are driven directly from registered counters, so they are glitch-free and stable for CLK_DIV clocks.
- On every `tick`, the output registers capture state for the current (h,v), before the counters advance:
  - RGB = vis ? `pixel_out` fields : 0.
  - `vga_hsync` = !(656 <= h < 752).
  - `vga_vsync` = !(490 <= v < 492).
- Colour and sync are registered together, so they stay aligned to each other.
- `rst` has priority over everything else. Reset values: `div`=0, h=0, v=0, `row_read`=0, `col_read`=0, RGB=0, `vga_hsync`=1, `vga_vsync`=1, `frame_start`=0.
- Reset mid-frame: every output takes its reset value on the next `clk`. The frame restarts from (0,0) with no partial sync pulse.

## Timing
- Address to data: `pixel_out` settles 1 `clk` after an address change and is sampled CLK_DIV-1 clocks later. This is why CLK_DIV must be 2 or more.
- Counter to pin: a counter value is visible on the pins one pixel period (CLK_DIV clocks) later. H and V syncs carry the same delay, so visible geometry is unchanged.
- Line: 800 ticks = 3200 `clk` at CLK_DIV=4.
- Frame: 420 000 ticks = 1 680 000 `clk` at CLK_DIV=4.
- Each buffer address is held for 2 ticks horizontally and 2 lines vertically.
- Simultaneous wrap of `h` and `v` takes one tick only. `frame_start` fires once per frame, never twice.
- `frame_start` stays at 0 after reset until the first wrap. It does not fire on the reset release itself.

## Structure
- Package `vga_timing_pkg` holds:
  - H/V timing constants and the derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
  - Buffer dimension constants: BUF_ROWS=240, BUF_COLS=320, PIX_W=12.
- Sub-module `vga_timing_gen` contains the divider, the `h`/`v` counters, `tick`, `vis`, the raw syncs and `frame_start`.
- The top level `vga_scanout` adds address generation and the output register stage.
- Benches instantiate `vga_scanout` together with `vga_buffer_ram`.

## Test plan
- Preload (0,0)=0xAAA, (0,1)=0xBBB, (1,0)=0xCCC, then release reset:
  - Screen pixels x0–1 show R=G=B=A; x2–3 show B.
  - Lines 2–3 start with C.
  - Blanking is 0.
- Sync timing (CLK_DIV=4):
  - `vga_hsync` low exactly 384 `clk`, falling 2624 `clk` + 4 after line start.
  - `vga_vsync` low exactly 2 lines (6400 `clk`).
- Address sweep: `col_read` steps 0..319, each value held 8 `clk`. `row_read` steps 0..239, each value held 2 lines. Both read 0 during blanking.
- `frame_start` pulses are exactly 1 `clk` wide, every 1 680 000 `clk`.
- Assert `rst` at h=300, v=100 for 1 `clk`:
  - Next `clk`: every output at its reset value.
  - Following frame timing identical to the first frame after power-up.
- CLK_DIV=2 regression: same image and sync checks as above at half the `clk` counts.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing and frame-buffer constants for the VGA scan-out path.
// Defaults describe 640x480@60 Hz driven from a 100 MHz system clock.
package vga_timing_pkg;

   localparam int CLK_DIV_DEFAULT = 4;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int HS_START = H_VIS + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int VS_START = V_VIS + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam int BUF_ROWS = 240;
   localparam int BUF_COLS = 320;
   localparam int PIX_W    = 12;

   // Widths of the counters, buffer addresses and colour channels
   localparam int CNT_W = 10;
   localparam int ROW_W = 8;
   localparam int COL_W = 9;
   localparam int CH_W  = 4;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider plus horizontal/vertical raster counters.
// Produces the pixel tick, visible-area flag, raw (unregistered) active-low
// syncs for the current counter position, and a one-clock frame_start pulse.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT,
   parameter int H_VIS_P  = H_VIS,
   parameter int H_FP_P   = H_FP,
   parameter int H_SYNC_P = H_SYNC,
   parameter int H_BP_P   = H_BP,
   parameter int V_VIS_P  = V_VIS,
   parameter int V_FP_P   = V_FP,
   parameter int V_SYNC_P = V_SYNC,
   parameter int V_BP_P   = V_BP
)(
   input  logic             clk,
   input  logic             rst,
   output logic             tick,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             vis,
   output logic             hsync_raw,
   output logic             vsync_raw,
   output logic             frame_start
);

   localparam int LINE_LEN    = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
   localparam int FRAME_LINES = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;
   localparam int DIV_W       = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LINE_LEN - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(FRAME_LINES - 1);
   localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS_P);
   localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS_P);
   localparam logic [CNT_W-1:0] HS_ON    = CNT_W'(H_VIS_P + H_FP_P);
   localparam logic [CNT_W-1:0] HS_OFF   = CNT_W'(H_VIS_P + H_FP_P + H_SYNC_P);
   localparam logic [CNT_W-1:0] VS_ON    = CNT_W'(V_VIS_P + V_FP_P);
   localparam logic [CNT_W-1:0] VS_OFF   = CNT_W'(V_VIS_P + V_FP_P + V_SYNC_P);

   logic [DIV_W-1:0] div;
   logic             h_wrap;
   logic             v_wrap;

   assign tick   = (div == DIV_LAST);
   assign h_wrap = (h == H_LAST);
   assign v_wrap = (v == V_LAST);

   // Divide the system clock down to one tick per VGA pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Raster position: h steps each tick, v steps when h wraps, both wrap together at frame end
   always_ff @(posedge clk) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (tick) begin
         if (h_wrap) begin
            h <= '0;
            v <= v_wrap ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   // One-clock pulse on the edge where both counters return to the origin
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick && h_wrap && v_wrap;
      end
   end

   // Visible-area flag and active-low sync windows for the current position
   always_comb begin
      vis       = (h < H_VIS_C) && (v < V_VIS_C);
      hsync_raw = !((h >= HS_ON) && (h < HS_OFF));
      vsync_raw = !((v >= VS_ON) && (v < VS_OFF));
   end

endmodule

// File: rtl/vga_scanout.sv
// Read side of the 320x240 frame buffer: walks the raster, requests each stored
// pixel for a 2x2 screen block, and registers colour and syncs together so the
// pins stay mutually aligned one pixel period behind the counters.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT,
   parameter int H_VIS_P  = H_VIS,
   parameter int H_FP_P   = H_FP,
   parameter int H_SYNC_P = H_SYNC,
   parameter int H_BP_P   = H_BP,
   parameter int V_VIS_P  = V_VIS,
   parameter int V_FP_P   = V_FP,
   parameter int V_SYNC_P = V_SYNC,
   parameter int V_BP_P   = V_BP
)(
   input  logic             clk,
   input  logic             rst,
   output logic [ROW_W-1:0] row_read,
   output logic [COL_W-1:0] col_read,
   input  logic [PIX_W-1:0] pixel_out,
   output logic [CH_W-1:0]  vga_red,
   output logic [CH_W-1:0]  vga_green,
   output logic [CH_W-1:0]  vga_blue,
   output logic             vga_hsync,
   output logic             vga_vsync,
   output logic             frame_start
);

   logic             tick;
   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   logic             vis;
   logic             hsync_raw;
   logic             vsync_raw;

   vga_timing_gen #(
      .CLK_DIV  (CLK_DIV),
      .H_VIS_P  (H_VIS_P),
      .H_FP_P   (H_FP_P),
      .H_SYNC_P (H_SYNC_P),
      .H_BP_P   (H_BP_P),
      .V_VIS_P  (V_VIS_P),
      .V_FP_P   (V_FP_P),
      .V_SYNC_P (V_SYNC_P),
      .V_BP_P   (V_BP_P)
   ) timing (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .h           (h),
      .v           (v),
      .vis         (vis),
      .hsync_raw   (hsync_raw),
      .vsync_raw   (vsync_raw),
      .frame_start (frame_start)
   );

   // Halve the screen position to get the buffer address; park at 0 while blanking
   always_comb begin
      col_read = '0;
      row_read = '0;
      if (vis) begin
         col_read = COL_W'(h >> 1);
         row_read = ROW_W'(v >> 1);
      end
   end

   // On each pixel tick latch colour and syncs for the position being left
   always_ff @(posedge clk) begin
      if (rst) begin
         vga_red   <= '0;
         vga_green <= '0;
         vga_blue  <= '0;
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
      end else if (tick) begin
         if (vis) begin
            vga_red   <= pixel_out[11:8];
            vga_green <= pixel_out[7:4];
            vga_blue  <= pixel_out[3:0];
         end else begin
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
         end
         vga_hsync <= hsync_raw;
         vga_vsync <= vsync_raw;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (CLK_DIV 4 and 2) on a shrunken raster,
// each reading a behavioural buffer RAM filled with random pixels. A closed-form
// raster model predicts every output every cycle; literal checks pin the model.
module tb_vga_scanout;

   localparam int HV = 20;
   localparam int HF = 3;
   localparam int HSW = 4;
   localparam int HB = 5;
   localparam int VV = 12;
   localparam int VF = 2;
   localparam int VSW = 2;
   localparam int VB = 3;
   localparam int HL = HV + HF + HSW + HB;
   localparam int VL = VV + VF + VSW + VB;
   localparam int FRAME = HL * VL;
   localparam int HSS = HV + HF;
   localparam int HSE = HSS + HSW;
   localparam int VSS = VV + VF;
   localparam int VSE = VSS + VSW;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [11:0] mem [0:239][0:319];

   logic [7:0]  row4, row2;
   logic [8:0]  col4, col2;
   logic [11:0] pix4, pix2;
   logic [3:0]  red4, green4, blue4, red2, green2, blue2;
   logic        hs4, vs4, fs4, hs2, vs2, fs2;

   int k = 0;
   logic model_valid = 1'b0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   vga_scanout #(
      .CLK_DIV(4), .H_VIS_P(HV), .H_FP_P(HF), .H_SYNC_P(HSW), .H_BP_P(HB),
      .V_VIS_P(VV), .V_FP_P(VF), .V_SYNC_P(VSW), .V_BP_P(VB)
   ) dut4 (
      .clk(clk), .rst(rst), .row_read(row4), .col_read(col4), .pixel_out(pix4),
      .vga_red(red4), .vga_green(green4), .vga_blue(blue4),
      .vga_hsync(hs4), .vga_vsync(vs4), .frame_start(fs4)
   );

   vga_scanout #(
      .CLK_DIV(2), .H_VIS_P(HV), .H_FP_P(HF), .H_SYNC_P(HSW), .H_BP_P(HB),
      .V_VIS_P(VV), .V_FP_P(VF), .V_SYNC_P(VSW), .V_BP_P(VB)
   ) dut2 (
      .clk(clk), .rst(rst), .row_read(row2), .col_read(col2), .pixel_out(pix2),
      .vga_red(red2), .vga_green(green2), .vga_blue(blue2),
      .vga_hsync(hs2), .vga_vsync(vs2), .frame_start(fs2)
   );

   // Buffer RAM read ports: data one clock after the address
   always @(posedge clk) begin
      pix4 <= mem[row4][col4];
      pix2 <= mem[row2][col2];
   end

   // Clocks since the last reset edge
   always @(posedge clk) begin
      if (rst) begin
         k <= 0;
         model_valid <= 1'b1;
      end else begin
         k <= k + 1;
      end
   end

   // Expected {row,col,rgb,hsync,vsync,frame_start} after kk clocks out of reset
   function automatic logic [31:0] expect_out(input int kk, input int d);
      int t, p, h, v, q, ph, pv;
      logic [7:0]  row;
      logic [8:0]  col;
      logic [11:0] rgb;
      logic        hs, vs, fs;
      t = kk / d;
      p = t % FRAME;
      h = p % HL;
      v = p / HL;
      row = '0;
      col = '0;
      if (h < HV && v < VV) begin
         col = 9'(h / 2);
         row = 8'(v / 2);
      end
      rgb = '0;
      hs = 1'b1;
      vs = 1'b1;
      fs = 1'b0;
      if (t > 0) begin
         q  = (t - 1) % FRAME;
         ph = q % HL;
         pv = q / HL;
         if (ph < HV && pv < VV) rgb = mem[pv / 2][ph / 2];
         hs = !(ph >= HSS && ph < HSE);
         vs = !(pv >= VSS && pv < VSE);
         fs = (kk % d == 0) && (t % FRAME == 0);
      end
      return {row, col, rgb, hs, vs, fs};
   endfunction

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (model_valid) begin
         logic [31:0] e4, e2, a4, a2;
         e4 = expect_out(k, 4);
         e2 = expect_out(k, 2);
         a4 = {row4, col4, red4, green4, blue4, hs4, vs4, fs4};
         a2 = {row2, col2, red2, green2, blue2, hs2, vs2, fs2};
         total++;
         if (a4 !== e4) begin
            bad++;
            $display("[TB] FAIL div4_model k=%0d actual=%h required=%h", k, a4, e4);
         end
         total++;
         if (a2 !== e2) begin
            bad++;
            $display("[TB] FAIL div2_model k=%0d actual=%h required=%h", k, a2, e2);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s k=%0d actual=%h required=%h", name, k, actual, required);
      end
   endtask

   // Advance to the negedge where k equals target, bounded
   task automatic wait_k(input int target);
      for (int i = 0; i < 20000 && k != target; i++) @(negedge clk);
      if (k != target) begin
         total++;
         bad++;
         $display("[TB] FAIL wait_timeout k=%0d required=%0d", k, target);
      end
   endtask

   task automatic applyStimulus(input int hold);
      @(negedge clk);
      rst = 1'b1;
      repeat (hold) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int r;
      for (int y = 0; y < 240; y++)
         for (int x = 0; x < 320; x++)
            mem[y][x] = 12'($urandom);
      mem[0][0] = 12'hAAA;
      mem[0][1] = 12'hBBB;
      mem[1][0] = 12'hCCC;

      applyStimulus(3);
      checkOutput("reset_div4", {row4, col4, red4, green4, blue4, hs4, vs4, fs4}, 32'h0000_0006);
      checkOutput("reset_div2", {row2, col2, red2, green2, blue2, hs2, vs2, fs2}, 32'h0000_0006);

      wait_k(2);    checkOutput("div2_x0_A", {20'd0, red2, green2, blue2}, 32'hAAA);
      wait_k(4);    checkOutput("div4_x0_A", {20'd0, red4, green4, blue4}, 32'hAAA);
      wait_k(6);    checkOutput("div2_x2_B", {20'd0, red2, green2, blue2}, 32'hBBB);
      wait_k(7);    checkOutput("div4_col_0", {23'd0, col4}, 32'd0);
      wait_k(8);    checkOutput("div4_col_1", {23'd0, col4}, 32'd1);
      wait_k(11);   checkOutput("div4_x1_A", {20'd0, red4, green4, blue4}, 32'hAAA);
      wait_k(12);   checkOutput("div4_x2_B", {20'd0, red4, green4, blue4}, 32'hBBB);
      wait_k(47);   checkOutput("div2_hs_before", {31'd0, hs2}, 32'd1);
      wait_k(48);   checkOutput("div2_hs_fall", {31'd0, hs2}, 32'd0);
      wait_k(56);   checkOutput("div2_hs_rise", {31'd0, hs2}, 32'd1);
      wait_k(84);   checkOutput("div4_blank", {20'd0, red4, green4, blue4}, 32'h0);
      wait_k(95);   checkOutput("div4_hs_before", {31'd0, hs4}, 32'd1);
      wait_k(96);   checkOutput("div4_hs_fall", {31'd0, hs4}, 32'd0);
      wait_k(111);  checkOutput("div4_hs_last", {31'd0, hs4}, 32'd0);
      wait_k(112);  checkOutput("div4_hs_rise", {31'd0, hs4}, 32'd1);
      wait_k(260);  checkOutput("div4_line2_C", {20'd0, red4, green4, blue4}, 32'hCCC);
      wait_k(388);  checkOutput("div4_line3_C", {20'd0, red4, green4, blue4}, 32'hCCC);
      wait_k(1216); checkOutput("div2_fs_pulse", {31'd0, fs2}, 32'd1);
      wait_k(1217); checkOutput("div2_fs_clear", {31'd0, fs2}, 32'd0);
      wait_k(1795); checkOutput("div4_vs_before", {31'd0, vs4}, 32'd1);
      wait_k(1796); checkOutput("div4_vs_fall", {31'd0, vs4}, 32'd0);
      wait_k(2051); checkOutput("div4_vs_last", {31'd0, vs4}, 32'd0);
      wait_k(2052); checkOutput("div4_vs_rise", {31'd0, vs4}, 32'd1);
      wait_k(2431); checkOutput("div4_fs_before", {31'd0, fs4}, 32'd0);
      wait_k(2432); checkOutput("div4_fs_pulse", {31'd0, fs4}, 32'd1);
      wait_k(2433); checkOutput("div4_fs_clear", {31'd0, fs4}, 32'd0);

      r = $urandom_range(1600, 800);
      wait_k(2432 + r);
      $display("[TB] mid-frame reset at k=%0d", k);
      applyStimulus(1);
      checkOutput("midreset_div4", {row4, col4, red4, green4, blue4, hs4, vs4, fs4}, 32'h0000_0006);
      checkOutput("midreset_div2", {row2, col2, red2, green2, blue2, hs2, vs2, fs2}, 32'h0000_0006);
      wait_k(4);    checkOutput("restart_div4_A", {20'd0, red4, green4, blue4}, 32'hAAA);
      wait_k(95);   checkOutput("restart_hs_before", {31'd0, hs4}, 32'd1);
      wait_k(96);   checkOutput("restart_hs_fall", {31'd0, hs4}, 32'd0);
      wait_k(2431); checkOutput("restart_fs_before", {31'd0, fs4}, 32'd0);
      wait_k(2432); checkOutput("restart_fs_pulse", {31'd0, fs4}, 32'd1);
      wait_k(2500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
